y86_decode_stage_p: RTL and testbench
=====================================

Name: y86_decode_stage_p

Overview:
- Parametrised next-generation Y86-64 decode stage for the 5-stage pipeline.
- Register-file width, depth and stack-pointer reset value are parameters.
- Register-file writes are synchronous, and a reset is added.
- Forwarding uses the standard priority network. The E pipeline register supports stall as well as bubble.
- Sits between the D pipeline register and the execute stage, and receives write-back from the W register.

Parameters:
- XLEN, 64, data width of registers, valC, valP and all forwarded values.
- NREGS, 15, number of architectural registers (indices 0..NREGS-1; 4'hF = RNONE).
- SP_IDX, 4, index of %rsp used by call, ret, pushq and popq.
- SP_RESET, 1023, reset value of register SP_IDX.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- D_stat  in  3  status from the D register.
- D_icode, D_ifun, D_rA, D_rB  in  4 each  decoded instruction fields.
- D_valC, D_valP  in  XLEN each  constant and next PC.
- E_bubble  in  1  load a nop into the E register.
- E_stall  in  1  hold the E register.
- e_dstE  in  4, e_valE  in  XLEN  execute-stage result.
- M_dstE  in  4, M_valE  in  XLEN  memory-stage ALU result.
- M_dstM  in  4, m_valM  in  XLEN  memory-stage load data.
- W_dstE  in  4, W_valE  in  XLEN  write-back E port.
- W_dstM  in  4, W_valM  in  XLEN  write-back M port.
- d_srcA, d_srcB  out  4 each  combinational source IDs, to hazard control.
- E_stat  out  3, E_icode  out  4, E_ifun  out  4  registered to execute.
- E_valC, E_valA, E_valB  out  XLEN each  registered to execute.
- E_dstE, E_dstM, E_srcA, E_srcB  out  4 each  registered to execute.
- regs_flat  out  NREGS*XLEN  register r at bits [r*XLEN +: XLEN]; debug view.

Behaviour:
- Decode table, combinational, by D_icode. Order of each entry: srcA, srcB, dstE, dstM. F = RNONE, SP = SP_IDX.
  - 2 cmov: rA, F, rB, F.
  - 3 irmovq: F, F, rB, F.
  - 4 rmmovq: rA, rB, F, F.
  - 5 mrmovq: F, rB, F, rA.
  - 6 OPq: rA, rB, rB, F.
  - 8 call: F, SP, SP, F.
  - 9 ret: SP, SP, SP, F.
  - A pushq: rA, SP, SP, F.
  - B popq: SP, SP, SP, rA.
  - Every other icode: all F.
- Register read, combinational:
  - A read of F returns 0.
  - A read of any index >= NREGS returns 0.
- d_valA priority:
  - icode 7 or 8 gives D_valP.
  - Otherwise the first source whose ID matches srcA, in this order: e_dstE, M_dstM, M_dstE, W_dstM, W_dstE.
  - A source only matches if its ID is != F.
  - If nothing matches, the register file value.
- d_valB: same priority chain against srcB, without the valP rule.
- W-stage forwarding covers the same-cycle write, so a read never observes stale data.
- Register file write, at posedge when reset=0:
  - If W_dstE != F and W_dstE < NREGS, write W_valE.
  - Then, if W_dstM != F and W_dstM < NREGS, write W_valM. W_dstM wins when W_dstM == W_dstE (popq %rsp).
  - Out-of-range indices are silently ignored.
- E register update, priority reset > E_bubble > E_stall > load.
  - reset: E register takes the nop state (see below). Register file is zeroed except SP_IDX = SP_RESET.
  - E_bubble: E register takes the nop state. The register file still accepts writes.
  - E_stall: all E_* hold their values. The register file still accepts writes.
  - load: E_* <= D_*, d_val*, d_src*, d_dst*.
  - Nop state: E_stat=1, E_icode=1, E_ifun=0, E_valC=E_valA=E_valB=0, E_dstE=E_dstM=E_srcA=E_srcB=F.
- Latency: one cycle from D inputs to E outputs. Register writes are visible in regs_flat one cycle after the edge.
- Reset mid-operation discards the in-flight E contents. No reset is needed before the first instruction other than the initial reset.
- No $display in synthesised paths.

Optional Feature:
- Macro: Y86_LOAD_USE_DETECT_EN.
- When defined:
  - Extra output d_load_use (1 bit, combinational).
  - d_load_use = 1 when E_icode is 5 or B and E_dstM != F and E_dstM equals d_srcA or d_srcB.
  - While d_load_use=1 and E_bubble=0 and E_stall=0, the E register loads the nop state internally. Hazard control uses d_load_use to stall F/D.
- When not defined: the port is absent, and the E register follows E_bubble/E_stall only.

Test Plan:
- Reset: assert reset 1 cycle -> regs_flat SP slot = 1023, all other slots 0; E_icode=1, E_dstE=F.
- Forward priority: D=OPq rA=2 rB=3; e_dstE=2 (e_valE=7) and M_dstE=2 (M_valE=9) -> E_valA=7. Drop e_dstE to F -> E_valA=9.
- popq %rsp: W_dstE=4, W_valE=1031, W_dstM=4, W_valM=55 -> register 4 = 55 next cycle.
- Stall vs bubble: load irmovq rB=1, then E_stall=1 for 2 cycles -> E_* unchanged. Then E_bubble=1 and E_stall=1 together -> nop state.
- call: D_icode=8, D_valP=0x40, register 4 = 1023 -> E_valA=0x40, E_valB=1023, E_dstE=4.
- Y86_LOAD_USE_DETECT_EN: E holds mrmovq with E_dstM=3, D=OPq rA=3 -> d_load_use=1 and the E register takes the nop state next cycle.

Source files
------------

// File: rtl/y86_decode_stage_p.sv
// ---------------------------------------------------------------------------
// y86_decode_stage_p
// Y86-64 decode stage for the 5-stage pipeline. It sits between the D and E
// pipeline registers, holds the architectural register file, and is written
// back from the W register.
//
// Parameters
//   XLEN     : data width of registers and of all forwarded values
//   NREGS    : number of architectural registers (4'hF is RNONE)
//   SP_IDX   : index of %rsp (used by call/ret/pushq/popq)
//   SP_RESET : reset value of register SP_IDX
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   D_*                   : instruction fields from the D register
//   E_bubble / E_stall    : hazard control for the E register
//   e_/M_/W_ dst & val    : forwarding sources (W also writes the regfile)
//   d_srcA / d_srcB       : combinational source IDs to hazard control
//   E_*                   : registered outputs to execute
//   regs_flat             : debug view, register r at [r*XLEN +: XLEN]
//   d_load_use            : load/use hazard flag (only with the macro below)
//
// Optional feature: define Y86_LOAD_USE_DETECT_EN to add d_load_use and to
// make the E register take a nop when a load/use hazard is detected.
// ---------------------------------------------------------------------------
module y86_decode_stage_p #(
  parameter int XLEN     = 64,
  parameter int NREGS    = 15,
  parameter int SP_IDX   = 4,
  parameter int SP_RESET = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            D_stat,
  input  logic [3:0]            D_icode,
  input  logic [3:0]            D_ifun,
  input  logic [3:0]            D_rA,
  input  logic [3:0]            D_rB,
  input  logic [XLEN-1:0]       D_valC,
  input  logic [XLEN-1:0]       D_valP,
  input  logic                  E_bubble,
  input  logic                  E_stall,
  input  logic [3:0]            e_dstE,
  input  logic [XLEN-1:0]       e_valE,
  input  logic [3:0]            M_dstE,
  input  logic [XLEN-1:0]       M_valE,
  input  logic [3:0]            M_dstM,
  input  logic [XLEN-1:0]       m_valM,
  input  logic [3:0]            W_dstE,
  input  logic [XLEN-1:0]       W_valE,
  input  logic [3:0]            W_dstM,
  input  logic [XLEN-1:0]       W_valM,
  output logic [3:0]            d_srcA,
  output logic [3:0]            d_srcB,
  output logic [2:0]            E_stat,
  output logic [3:0]            E_icode,
  output logic [3:0]            E_ifun,
  output logic [XLEN-1:0]       E_valC,
  output logic [XLEN-1:0]       E_valA,
  output logic [XLEN-1:0]       E_valB,
  output logic [3:0]            E_dstE,
  output logic [3:0]            E_dstM,
  output logic [3:0]            E_srcA,
  output logic [3:0]            E_srcB,
`ifdef Y86_LOAD_USE_DETECT_EN
  output logic                  d_load_use,
`endif
  output logic [NREGS*XLEN-1:0] regs_flat
);

  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] SP      = 4'(SP_IDX);
  localparam logic [3:0] I_CMOV  = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OPQ   = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  typedef struct packed {
    logic [2:0]      stat;
    logic [3:0]      icode;
    logic [3:0]      ifun;
    logic [XLEN-1:0] valc;
    logic [XLEN-1:0] vala;
    logic [XLEN-1:0] valb;
    logic [3:0]      dste;
    logic [3:0]      dstm;
    logic [3:0]      srca;
    logic [3:0]      srcb;
  } ereg_t;

  logic [XLEN-1:0] rf_q [NREGS];
  logic [XLEN-1:0] rf_d [NREGS];
  ereg_t           ereg_q;
  ereg_t           ereg_d;

  logic [3:0]      d_dste;
  logic [3:0]      d_dstm;
  logic [XLEN-1:0] rf_a;
  logic [XLEN-1:0] rf_b;
  logic [XLEN-1:0] d_vala;
  logic [XLEN-1:0] d_valb;
  logic            load_use;

  // The bubble/reset contents of the E register: a nop with AOK status.
  function automatic ereg_t ereg_nop();
    ereg_t n;
    n.stat  = 3'd1;
    n.icode = 4'h1;
    n.ifun  = 4'h0;
    n.valc  = '0;
    n.vala  = '0;
    n.valb  = '0;
    n.dste  = RNONE;
    n.dstm  = RNONE;
    n.srca  = RNONE;
    n.srcb  = RNONE;
    return n;
  endfunction

  // Forwarding priority: newest producer first. W_dstM precedes W_dstE so a
  // popq %rsp in write-back forwards the popped value, matching the regfile.
  function automatic logic [XLEN-1:0] fwd(input logic [3:0] src,
                                          input logic [XLEN-1:0] rf_val);
    logic [XLEN-1:0] v;
    if (src == RNONE)        v = rf_val;
    else if (src == e_dstE)  v = e_valE;
    else if (src == M_dstM)  v = m_valM;
    else if (src == M_dstE)  v = M_valE;
    else if (src == W_dstM)  v = W_valM;
    else if (src == W_dstE)  v = W_valE;
    else                     v = rf_val;
    return v;
  endfunction

  // Decode table: register IDs read and written by each instruction class.
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dste = RNONE;
    d_dstm = RNONE;
    case (D_icode)
      I_CMOV:  begin d_srcA = D_rA;                d_dste = D_rB; end
      I_IRMOV: begin                               d_dste = D_rB; end
      I_RMMOV: begin d_srcA = D_rA; d_srcB = D_rB;                end
      I_MRMOV: begin d_srcB = D_rB;                d_dstm = D_rA; end
      I_OPQ:   begin d_srcA = D_rA; d_srcB = D_rB; d_dste = D_rB; end
      I_CALL:  begin d_srcB = SP;                  d_dste = SP;   end
      I_RET:   begin d_srcA = SP;   d_srcB = SP;   d_dste = SP;   end
      I_PUSH:  begin d_srcA = D_rA; d_srcB = SP;   d_dste = SP;   end
      I_POP:   begin d_srcA = SP;   d_srcB = SP;   d_dste = SP; d_dstm = D_rA; end
      default: begin d_srcA = RNONE; d_srcB = RNONE; d_dste = RNONE; d_dstm = RNONE; end
    endcase
  end

  // Register file read ports; RNONE and indices beyond NREGS read as zero.
  always_comb begin
    rf_a = '0;
    rf_b = '0;
    for (int r = 0; r < NREGS; r++) begin
      rf_a = (d_srcA != RNONE && d_srcA == 4'(r)) ? rf_q[r] : rf_a;
      rf_b = (d_srcB != RNONE && d_srcB == 4'(r)) ? rf_q[r] : rf_b;
    end
  end

  // Operand selection: jXX/call carry valP in valA, otherwise forward.
  always_comb begin
    d_vala = (D_icode == I_JXX || D_icode == I_CALL) ? D_valP : fwd(d_srcA, rf_a);
    d_valb = fwd(d_srcB, rf_b);
  end

`ifdef Y86_LOAD_USE_DETECT_EN
  // Load/use hazard: the load in E produces a register decode wants now.
  always_comb begin
    load_use = (ereg_q.icode == I_MRMOV || ereg_q.icode == I_POP) &&
               (ereg_q.dstm != RNONE) &&
               (ereg_q.dstm == d_srcA || ereg_q.dstm == d_srcB);
  end
  assign d_load_use = load_use;
`else
  assign load_use = 1'b0;
`endif

  // Register file next state: E port first, M port overrides on a clash.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      rf_d[r] = rf_q[r];
      rf_d[r] = (W_dstE != RNONE && W_dstE == 4'(r)) ? W_valE : rf_d[r];
      rf_d[r] = (W_dstM != RNONE && W_dstM == 4'(r)) ? W_valM : rf_d[r];
    end
  end

  // E register next state: bubble beats stall; hazard nop only when loading.
  always_comb begin
    ereg_d = ereg_q;
    if (E_bubble) begin
      ereg_d = ereg_nop();
    end else if (E_stall) begin
      ereg_d = ereg_q;
    end else if (load_use) begin
      ereg_d = ereg_nop();
    end else begin
      ereg_d.stat  = D_stat;
      ereg_d.icode = D_icode;
      ereg_d.ifun  = D_ifun;
      ereg_d.valc  = D_valC;
      ereg_d.vala  = d_vala;
      ereg_d.valb  = d_valb;
      ereg_d.dste  = d_dste;
      ereg_d.dstm  = d_dstm;
      ereg_d.srca  = d_srcA;
      ereg_d.srcb  = d_srcB;
    end
  end

  // State registers: register file and E pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        rf_q[r] <= (r == SP_IDX) ? XLEN'(SP_RESET) : '0;
      end
      ereg_q <= ereg_nop();
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        rf_q[r] <= rf_d[r];
      end
      ereg_q <= ereg_d;
    end
  end

  assign E_stat  = ereg_q.stat;
  assign E_icode = ereg_q.icode;
  assign E_ifun  = ereg_q.ifun;
  assign E_valC  = ereg_q.valc;
  assign E_valA  = ereg_q.vala;
  assign E_valB  = ereg_q.valb;
  assign E_dstE  = ereg_q.dste;
  assign E_dstM  = ereg_q.dstm;
  assign E_srcA  = ereg_q.srca;
  assign E_srcB  = ereg_q.srcb;

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[g*XLEN +: XLEN] = rf_q[g];
  end

endmodule

// File: tb/tb_y86_decode_stage_p.sv
// Scoreboard bench for y86_decode_stage_p: the driver applies one vector per
// cycle, runs a reference model and queues the expected post-edge state; the
// monitor pops one entry after each rising edge and compares.
module tb_y86_decode_stage_p;
  localparam int XLEN = 64;
  localparam int NREGS = 15;
  localparam logic [3:0] F = 4'hF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, E_bubble, E_stall;
  logic [2:0] D_stat;
  logic [3:0] D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [3:0] e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0] d_srcA, d_srcB;
  logic [2:0] E_stat;
  logic [3:0] E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [NREGS*XLEN-1:0] regs_flat;
`ifdef Y86_LOAD_USE_DETECT_EN
  logic d_load_use;
`endif

  y86_decode_stage_p dut (
    .clk(clk), .reset(reset), .D_stat(D_stat), .D_icode(D_icode),
    .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC),
    .D_valP(D_valP), .E_bubble(E_bubble), .E_stall(E_stall),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_valC(E_valC),
    .E_valA(E_valA), .E_valB(E_valB), .E_dstE(E_dstE), .E_dstM(E_dstM),
    .E_srcA(E_srcA), .E_srcB(E_srcB),
`ifdef Y86_LOAD_USE_DETECT_EN
    .d_load_use(d_load_use),
`endif
    .regs_flat(regs_flat)
  );

  typedef struct packed {
    logic rst, bub, stl;
    logic [2:0] stat;
    logic [3:0] ic, ifn, ra, rb;
    logic [63:0] valc, valp;
    logic [3:0] ed, mdm, mde, wdm, wde;
    logic [63:0] ev, mm, me, wm, we;
  } vec_t;

  typedef struct packed {
    logic [2:0] stat;
    logic [3:0] icode, ifun;
    logic [63:0] valc, vala, valb;
    logic [3:0] dste, dstm, srca, srcb;
    logic [3:0] dsa, dsb;
    logic lu;
    logic [NREGS*XLEN-1:0] regs;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  logic [63:0] mregs [NREGS];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural decode table: {srcA, srcB, dstE, dstM}.
  function automatic logic [15:0] decode(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb);
    case (ic)
      4'h2: return {ra, F, rb, F};
      4'h3: return {F, F, rb, F};
      4'h4: return {ra, rb, F, F};
      4'h5: return {F, rb, F, ra};
      4'h6: return {ra, rb, rb, F};
      4'h8: return {F, 4'd4, 4'd4, F};
      4'h9: return {4'd4, 4'd4, 4'd4, F};
      4'hA: return {ra, 4'd4, 4'd4, F};
      4'hB: return {4'd4, 4'd4, 4'd4, ra};
      default: return {F, F, F, F};
    endcase
  endfunction

  // Value of register s as decode sees it: newest in-flight producer wins.
  function automatic logic [63:0] operand(input logic [3:0] s, input vec_t v);
    logic [3:0] ids [5];
    logic [63:0] vals [5];
    ids = '{v.ed, v.mdm, v.mde, v.wdm, v.wde};
    vals = '{v.ev, v.mm, v.me, v.wm, v.we};
    if (s == F) return 64'd0;
    for (int i = 0; i < 5; i++) if (ids[i] == s) return vals[i];
    return mregs[int'(s)];
  endfunction

  function automatic exp_t make_nop(input exp_t base);
    exp_t n = base;
    n.stat = 3'd1; n.icode = 4'h1; n.ifun = 4'h0;
    n.valc = 64'd0; n.vala = 64'd0; n.valb = 64'd0;
    n.dste = F; n.dstm = F; n.srca = F; n.srcb = F;
    return n;
  endfunction

  function automatic logic hazard(input exp_t e, input logic [3:0] sa, input logic [3:0] sb);
`ifdef Y86_LOAD_USE_DETECT_EN
    return (e.icode == 4'h5 || e.icode == 4'hB) && e.dstm != F && (e.dstm == sa || e.dstm == sb);
`else
    return 1'b0;
`endif
  endfunction

  task automatic apply(input vec_t v);
    logic [15:0] dec;
    logic [3:0] sa, sb;
    exp_t nx;
    reset = v.rst; E_bubble = v.bub; E_stall = v.stl;
    D_stat = v.stat; D_icode = v.ic; D_ifun = v.ifn; D_rA = v.ra; D_rB = v.rb;
    D_valC = v.valc; D_valP = v.valp;
    e_dstE = v.ed; e_valE = v.ev; M_dstM = v.mdm; m_valM = v.mm;
    M_dstE = v.mde; M_valE = v.me; W_dstM = v.wdm; W_valM = v.wm;
    W_dstE = v.wde; W_valE = v.we;
    dec = decode(v.ic, v.ra, v.rb);
    sa = dec[15:12];
    sb = dec[11:8];
    nx = cur;
    if (v.rst) begin
      nx = make_nop(cur);
      for (int r = 0; r < NREGS; r++) mregs[r] = (r == 4) ? 64'd1023 : 64'd0;
    end else begin
      if (v.bub) nx = make_nop(cur);
      else if (v.stl) nx = cur;
      else if (hazard(cur, sa, sb)) nx = make_nop(cur);
      else begin
        nx.stat = v.stat; nx.icode = v.ic; nx.ifun = v.ifn; nx.valc = v.valc;
        nx.vala = (v.ic == 4'h7 || v.ic == 4'h8) ? v.valp : operand(sa, v);
        nx.valb = operand(sb, v);
        nx.dste = dec[7:4]; nx.dstm = dec[3:0]; nx.srca = sa; nx.srcb = sb;
      end
      if (v.wde != F) mregs[int'(v.wde)] = v.we;
      if (v.wdm != F) mregs[int'(v.wdm)] = v.wm;
    end
    nx.dsa = sa;
    nx.dsb = sb;
    nx.lu = hazard(nx, sa, sb);
    for (int r = 0; r < NREGS; r++) nx.regs[r*XLEN +: XLEN] = mregs[r];
    exp_q.push_back(nx);
    cur = nx;
    @(negedge clk);
  endtask

  function automatic vec_t idle();
    vec_t v = '0;
    v.stat = 3'd1; v.ic = 4'h1;
    v.ra = F; v.rb = F;
    v.ed = F; v.mdm = F; v.mde = F; v.wdm = F; v.wde = F;
    return v;
  endfunction

  function automatic logic [3:0] rnd_id();
    return ($urandom_range(0, 2) == 0) ? F : 4'($urandom_range(0, 14));
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    v.rst = ($urandom_range(0, 63) == 0);
    v.bub = ($urandom_range(0, 7) == 0);
    v.stl = ($urandom_range(0, 7) == 0);
    v.stat = 3'($urandom_range(0, 7));
    v.ic = 4'($urandom_range(0, 15));
    v.ifn = 4'($urandom_range(0, 15));
    v.ra = rnd_id(); v.rb = rnd_id();
    v.valc = {$urandom, $urandom}; v.valp = {$urandom, $urandom};
    v.ed = rnd_id(); v.mdm = rnd_id(); v.mde = rnd_id(); v.wdm = rnd_id(); v.wde = rnd_id();
    v.ev = {$urandom, $urandom}; v.mm = {$urandom, $urandom}; v.me = {$urandom, $urandom};
    v.wm = {$urandom, $urandom}; v.we = {$urandom, $urandom};
    return v;
  endfunction

  // Monitor: one scoreboard entry per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        check("E_stat", 64'(E_stat), 64'(x.stat));
        check("E_icode", 64'(E_icode), 64'(x.icode));
        check("E_ifun", 64'(E_ifun), 64'(x.ifun));
        check("E_valC", E_valC, x.valc);
        check("E_valA", E_valA, x.vala);
        check("E_valB", E_valB, x.valb);
        check("E_dstE", 64'(E_dstE), 64'(x.dste));
        check("E_dstM", 64'(E_dstM), 64'(x.dstm));
        check("E_srcA", 64'(E_srcA), 64'(x.srca));
        check("E_srcB", 64'(E_srcB), 64'(x.srcb));
        check("d_srcA", 64'(d_srcA), 64'(x.dsa));
        check("d_srcB", 64'(d_srcB), 64'(x.dsb));
`ifdef Y86_LOAD_USE_DETECT_EN
        check("d_load_use", 64'(d_load_use), 64'(x.lu));
`endif
        for (int r = 0; r < NREGS; r++)
          check($sformatf("reg%0d", r), regs_flat[r*XLEN +: XLEN], x.regs[r*XLEN +: XLEN]);
      end
    end
  end

  // Driver: directed scenarios, then randomized traffic.
  initial begin
    vec_t v;
    cur = '0;
    for (int r = 0; r < NREGS; r++) mregs[r] = 64'd0;
    v = idle(); v.rst = 1'b1;
    apply(v);
    apply(v);
    // Forwarding priority: e beats M, then M once e is released.
    v = idle(); v.ic = 4'h6; v.ra = 4'd2; v.rb = 4'd3;
    v.ed = 4'd2; v.ev = 64'd7; v.mde = 4'd2; v.me = 64'd9;
    apply(v);
    v.ed = F;
    apply(v);
    // popq %rsp write-back: M port wins.
    v = idle(); v.wde = 4'd4; v.we = 64'd1031; v.wdm = 4'd4; v.wm = 64'd55;
    apply(v);
    apply(idle());
    // Stall holds, bubble overrides stall.
    v = idle(); v.ic = 4'h3; v.rb = 4'd1; v.valc = 64'h1234;
    apply(v);
    v = idle(); v.ic = 4'h6; v.ra = 4'd5; v.rb = 4'd6; v.stl = 1'b1;
    apply(v);
    apply(v);
    v.bub = 1'b1;
    apply(v);
    // call after reset sees %rsp = 1023.
    v = idle(); v.rst = 1'b1;
    apply(v);
    v = idle(); v.ic = 4'h8; v.valp = 64'h40;
    apply(v);
    // Load followed by a dependent OPq.
    v = idle(); v.ic = 4'h5; v.ra = 4'd3; v.rb = 4'd7;
    apply(v);
    v = idle(); v.ic = 4'h6; v.ra = 4'd3; v.rb = 4'd8;
    apply(v);
    apply(v);
    for (int i = 0; i < 600; i++) apply(rnd_vec());
    apply(idle());
    @(posedge clk);
    #2;
    check("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
